hwpe_stream_sink_job_sequencer: RTL and testbench

- Queues write-stream jobs (base address, transfer size, ID) from the controller or register file.
- Launches them back-to-back on one hwpe_stream_sink instance through its req_start / ready_start / done control handshake.
- Holds sink configuration stable for the whole job and reports per-job completion events.
- Sits between the HWPE controller FSM and the sink streamer so the controller need not sequence each transfer.

---
 rtl/hwpe_stream_sink_job_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_hwpe_stream_sink_job_sequencer.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_sink_job_sequencer.sv
// Job queue and launch sequencer for a single hwpe_stream_sink: pops {addr,size,id}
// jobs, runs the req_start/done handshake and reports completion. Optional: SINK_JOB_SEQ_WATCHDOG_EN.
module hwpe_stream_sink_job_sequencer #(
    parameter int unsigned JOB_FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SIZE_WIDTH     = 16,
    parameter int unsigned ID_WIDTH       = 4
`ifdef SINK_JOB_SEQ_WATCHDOG_EN
    ,
    parameter int unsigned WATCHDOG_CYCLES = 65535
`endif
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              job_valid_i,
    output logic                              job_ready_o,
    input  logic [ADDR_WIDTH-1:0]             job_addr_i,
    input  logic [SIZE_WIDTH-1:0]             job_size_i,
    input  logic [ID_WIDTH-1:0]               job_id_i,
    output logic                              sink_req_start_o,
    output logic [ADDR_WIDTH-1:0]             sink_addr_o,
    output logic [SIZE_WIDTH-1:0]             sink_size_o,
    input  logic                              sink_ready_start_i,
    input  logic                              sink_done_i,
    output logic                              evt_done_o,
    output logic                              evt_skip_o,
    output logic [ID_WIDTH-1:0]               evt_id_o,
    output logic                              busy_o,
    output logic [$clog2(JOB_FIFO_DEPTH):0]   pending_o
`ifdef SINK_JOB_SEQ_WATCHDOG_EN
    ,
    output logic                              err_timeout_o
`endif
);

    localparam int unsigned PTR_W = $clog2(JOB_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned JOB_W = ADDR_WIDTH + SIZE_WIDTH + ID_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(JOB_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, REPORT} state_e;

    state_e                 state_q, state_d;
    logic [JOB_W-1:0]       mem_q [JOB_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   full_q;
    logic                   push, pop, empty;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [SIZE_WIDTH-1:0]  head_size;
    logic [ID_WIDTH-1:0]    head_id;
    logic [ADDR_WIDTH-1:0]  cfg_addr_q;
    logic [SIZE_WIDTH-1:0]  cfg_size_q;
    logic [ID_WIDTH-1:0]    cfg_id_q;
    logic                   cfg_skip_q;
    logic                   wd_expire;

    assign empty = (cnt_q == '0);
    // Ready comes from the registered full flag only, so a pop never frees a slot in the same cycle.
    assign push  = job_valid_i & ~full_q;
    assign pop   = (state_q == IDLE) & ~empty & sink_ready_start_i;
    assign {head_addr, head_size, head_id} = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {job_addr_i, job_size_i, job_id_i};
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == DEPTH_C);
        end
    end

`ifdef SINK_JOB_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q      <= '0;
            err_timeout_o <= 1'b0;
        end else if (clear_i) begin
            wd_cnt_q      <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            if (state_q == LAUNCH)         wd_cnt_q <= '0;
            else if (state_q == WAIT_DONE) wd_cnt_q <= wd_cnt_q + 1'b1;
            if (wd_expire) err_timeout_o <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_d          = state_q;
        wd_expire        = 1'b0;
        sink_req_start_o = 1'b0;
        evt_done_o       = 1'b0;
        evt_skip_o       = 1'b0;
        evt_id_o         = '0;
        case (state_q)
            IDLE: begin
                // A zero-length job would never see done from the sink, so it is reported as skipped.
                if (pop) state_d = (head_size == '0) ? REPORT : LAUNCH;
            end
            LAUNCH: begin
                sink_req_start_o = 1'b1;
                state_d          = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (sink_done_i) begin
                    state_d = REPORT;
                end
`ifdef SINK_JOB_SEQ_WATCHDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d   = REPORT;
                    wd_expire = 1'b1;
                end
`endif
            end
            REPORT: begin
                evt_done_o = 1'b1;
                evt_skip_o = cfg_skip_q;
                evt_id_o   = cfg_id_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      state_q <= IDLE;
        else if (clear_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Sink configuration only moves on a pop, keeping it stable for the whole job.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_addr_q <= '0;
            cfg_size_q <= '0;
            cfg_id_q   <= '0;
            cfg_skip_q <= 1'b0;
        end else if (clear_i) begin
            cfg_addr_q <= '0;
            cfg_size_q <= '0;
            cfg_id_q   <= '0;
            cfg_skip_q <= 1'b0;
        end else if (pop) begin
            cfg_addr_q <= head_addr;
            cfg_size_q <= head_size;
            cfg_id_q   <= head_id;
            cfg_skip_q <= (head_size == '0);
        end else if (wd_expire) begin
            cfg_skip_q <= 1'b1;
        end
    end

    assign job_ready_o = ~full_q;
    assign sink_addr_o = cfg_addr_q;
    assign sink_size_o = cfg_size_q;
    assign pending_o   = cnt_q;
    assign busy_o      = (state_q != IDLE) | (cnt_q != '0);

endmodule

// File: tb/tb_hwpe_stream_sink_job_sequencer.sv
// Bench for hwpe_stream_sink_job_sequencer: behavioural sink model, launch/event logger,
// per-scenario tasks comparing against expectations derived from the job-queue rules.
`timescale 1ns/1ps
module tb_hwpe_stream_sink_job_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int SW    = 16;
    localparam int IW    = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    clear_i = 1'b0;
    logic                    job_valid_i = 1'b0;
    logic                    job_ready_o;
    logic [AW-1:0]           job_addr_i = '0;
    logic [SW-1:0]           job_size_i = '0;
    logic [IW-1:0]           job_id_i = '0;
    logic                    sink_req_start_o;
    logic [AW-1:0]           sink_addr_o;
    logic [SW-1:0]           sink_size_o;
    logic                    sink_ready_start_i = 1'b1;
    logic                    sink_done_i = 1'b0;
    logic                    evt_done_o;
    logic                    evt_skip_o;
    logic [IW-1:0]           evt_id_o;
    logic                    busy_o;
    logic [$clog2(DEPTH):0]  pending_o;
`ifdef SINK_JOB_SEQ_WATCHDOG_EN
    logic                    err_timeout_o;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    hwpe_stream_sink_job_sequencer #(
        .JOB_FIFO_DEPTH(DEPTH),
        .ADDR_WIDTH(AW),
        .SIZE_WIDTH(SW),
        .ID_WIDTH(IW)
`ifdef SINK_JOB_SEQ_WATCHDOG_EN
        ,
        .WATCHDOG_CYCLES(20)
`endif
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .clear_i(clear_i),
        .job_valid_i(job_valid_i),
        .job_ready_o(job_ready_o),
        .job_addr_i(job_addr_i),
        .job_size_i(job_size_i),
        .job_id_i(job_id_i),
        .sink_req_start_o(sink_req_start_o),
        .sink_addr_o(sink_addr_o),
        .sink_size_o(sink_size_o),
        .sink_ready_start_i(sink_ready_start_i),
        .sink_done_i(sink_done_i),
        .evt_done_o(evt_done_o),
        .evt_skip_o(evt_skip_o),
        .evt_id_o(evt_id_o),
        .busy_o(busy_o),
        .pending_o(pending_o)
`ifdef SINK_JOB_SEQ_WATCHDOG_EN
        ,
        .err_timeout_o(err_timeout_o)
`endif
    );

    initial forever #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Sink model: done arrives sk_lat cycles after the start request is seen.
    int sk_lat = 4;
    bit sk_stall = 1'b0;
    bit sk_never = 1'b0;
    bit sk_clear = 1'b0;
    bit sk_busy = 1'b0;
    int sk_cnt = 0;

    always @(negedge clk_i) begin
        sink_done_i = 1'b0;
        if (sk_clear) begin
            sk_busy = 1'b0;
        end else if (sk_busy) begin
            if (sk_cnt <= 1) begin
                sink_done_i = 1'b1;
                sk_busy = 1'b0;
            end else begin
                sk_cnt--;
            end
        end else if (sink_req_start_o && !sk_never) begin
            sk_busy = 1'b1;
            sk_cnt = sk_lat;
        end
        sink_ready_start_i = !sk_busy && !sk_stall;
    end

    typedef struct { logic [AW-1:0] addr; logic [SW-1:0] size; int cyc; } launch_t;
    typedef struct { logic [IW-1:0] id; logic skip; int cyc; } evt_t;

    launch_t lq[$];
    evt_t    eq[$];
    int      stable_err = 0;
    bit      in_job = 1'b0;
    logic [AW-1:0] ja = '0;
    logic [SW-1:0] js = '0;

    always @(negedge clk_i) begin
        if (clear_i) in_job = 1'b0;
        if (sink_req_start_o) begin
            lq.push_back('{sink_addr_o, sink_size_o, cyc});
            in_job = 1'b1;
            ja = sink_addr_o;
            js = sink_size_o;
        end else if (in_job && (sink_addr_o !== ja || sink_size_o !== js)) begin
            stable_err++;
        end
        if (evt_done_o) begin
            eq.push_back('{evt_id_o, evt_skip_o, cyc});
            in_job = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_job(input logic [AW-1:0] a, input logic [SW-1:0] s,
                            input logic [IW-1:0] id, output bit ok);
        job_valid_i = 1'b1;
        job_addr_i  = a;
        job_size_i  = s;
        job_id_i    = id;
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk_i);
            if (job_ready_o) ok = 1'b1;
            tick();
        end
        job_valid_i = 1'b0;
    endtask

    task automatic wait_events(input int target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (eq.size() >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        tests++;
        if (job_ready_o !== 1'b1) begin
            fails++; $display("FAIL reset_ready_in_reset: got %b expected 1", job_ready_o);
        end
        tests++;
        if ({sink_req_start_o, evt_done_o, evt_skip_o, evt_id_o, busy_o, pending_o,
             sink_addr_o, sink_size_o} !== '0) begin
            fails++; $display("FAIL reset_outputs_zero: got req=%b done=%b skip=%b id=%0h busy=%b pend=%0d addr=%0h size=%0h expected all 0",
                sink_req_start_o, evt_done_o, evt_skip_o, evt_id_o, busy_o, pending_o, sink_addr_o, sink_size_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        @(negedge clk_i);
        tests++;
        if (job_ready_o !== 1'b1 || busy_o !== 1'b0 || pending_o !== '0) begin
            fails++; $display("FAIL reset_after_release: got ready=%b busy=%b pend=%0d expected 1/0/0",
                job_ready_o, busy_o, pending_o);
        end
        tick();
    endtask

    task automatic test_single();
        int bl, be, t0, se;
        bit ok;
        bl = lq.size(); be = eq.size(); se = stable_err;
        sk_lat = 12;
        t0 = cyc;
        push_job(32'h1000, 16'd8, 4'd3, ok);
        @(negedge clk_i);
        tests++;
        if (!ok || pending_o !== 1 || busy_o !== 1'b1) begin
            fails++; $display("FAIL single_push: got ok=%b pend=%0d busy=%b expected 1/1/1", ok, pending_o, busy_o);
        end
        wait_events(be + 1, ok);
        repeat (2) tick();
        tests++;
        if (!ok || lq.size() != bl + 1) begin
            fails++; $display("FAIL single_counts: got launches=%0d events_ok=%b expected 1/1", lq.size() - bl, ok);
        end else begin
            tests++;
            if (lq[bl].cyc != t0 + 2) begin
                fails++; $display("FAIL single_launch_cyc: got %0d expected %0d", lq[bl].cyc, t0 + 2);
            end
            tests++;
            if (lq[bl].addr !== 32'h1000 || lq[bl].size !== 16'd8) begin
                fails++; $display("FAIL single_cfg: got addr=%0h size=%0d expected 1000/8", lq[bl].addr, lq[bl].size);
            end
            tests++;
            if (eq[be].cyc != t0 + 2 + 12 + 1) begin
                fails++; $display("FAIL single_evt_cyc: got %0d expected %0d", eq[be].cyc, t0 + 15);
            end
            tests++;
            if (eq[be].id !== 4'd3 || eq[be].skip !== 1'b0) begin
                fails++; $display("FAIL single_evt: got id=%0d skip=%b expected 3/0", eq[be].id, eq[be].skip);
            end
        end
        tests++;
        if (stable_err != se) begin
            fails++; $display("FAIL single_cfg_stable: got %0d changes expected 0", stable_err - se);
        end
        @(negedge clk_i);
        tests++;
        if (busy_o !== 1'b0) begin
            fails++; $display("FAIL single_idle_after: got busy=%b expected 0", busy_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int bl, be;
        bit ok;
        bit rdy[5];
        bl = lq.size(); be = eq.size();
        sk_lat = 4;
        sk_stall = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            job_valid_i = 1'b1;
            job_addr_i  = 32'h2000 + 32'(i * 16);
            job_size_i  = SW'(i + 1);
            job_id_i    = IW'(i);
            @(negedge clk_i);
            rdy[i] = job_ready_o;
            tick();
        end
        job_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (rdy[i] !== (i < DEPTH)) begin
                fails++; $display("FAIL b2b_ready_%0d: got %b expected %b", i, rdy[i], (i < DEPTH));
            end
        end
        @(negedge clk_i);
        tests++;
        if (pending_o !== 4 || job_ready_o !== 1'b0) begin
            fails++; $display("FAIL b2b_full: got pend=%0d ready=%b expected 4/0", pending_o, job_ready_o);
        end
        tick();
        // Release the sink and push into the full queue in the same cycle.
        sk_stall    = 1'b0;
        job_valid_i = 1'b1;
        job_addr_i  = 32'h2F00;
        job_size_i  = 16'd1;
        job_id_i    = 4'd9;
        @(negedge clk_i);
        tests++;
        if (job_ready_o !== 1'b0) begin
            fails++; $display("FAIL fullpop_ready: got %b expected 0", job_ready_o);
        end
        tick();
        job_valid_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (pending_o !== 3) begin
            fails++; $display("FAIL fullpop_pending: got %0d expected 3", pending_o);
        end
        wait_events(be + 4, ok);
        repeat (10) tick();
        tests++;
        if (!ok || eq.size() != be + 4 || lq.size() != bl + 4) begin
            fails++; $display("FAIL b2b_counts: got events=%0d launches=%0d expected 4/4", eq.size() - be, lq.size() - bl);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (eq[be + i].id !== IW'(i) || eq[be + i].skip !== 1'b0) begin
                    fails++; $display("FAIL b2b_evt_%0d: got id=%0d skip=%b expected %0d/0", i, eq[be + i].id, eq[be + i].skip, i);
                end
                tests++;
                if (lq[bl + i].addr !== 32'h2000 + 32'(i * 16) || lq[bl + i].size !== SW'(i + 1)) begin
                    fails++; $display("FAIL b2b_cfg_%0d: got addr=%0h size=%0d expected %0h/%0d",
                        i, lq[bl + i].addr, lq[bl + i].size, 32'h2000 + i * 16, i + 1);
                end
                if (i > 0) begin
                    tests++;
                    if (lq[bl + i].cyc - lq[bl + i - 1].cyc != sk_lat + 3) begin
                        fails++; $display("FAIL b2b_gap_%0d: got %0d expected %0d", i,
                            lq[bl + i].cyc - lq[bl + i - 1].cyc, sk_lat + 3);
                    end
                end
            end
        end
    endtask

    task automatic test_skip();
        int bl, be;
        bit ok;
        bl = lq.size(); be = eq.size();
        sk_lat = 3;
        push_job(32'h3000, 16'd5, 4'd1, ok);
        push_job(32'h3100, 16'd0, 4'd7, ok);
        push_job(32'h3200, 16'd6, 4'd2, ok);
        wait_events(be + 3, ok);
        repeat (4) tick();
        tests++;
        if (!ok || eq.size() != be + 3 || lq.size() != bl + 2) begin
            fails++; $display("FAIL skip_counts: got events=%0d launches=%0d expected 3/2", eq.size() - be, lq.size() - bl);
        end else begin
            tests++;
            if (lq[bl].addr !== 32'h3000 || lq[bl + 1].addr !== 32'h3200) begin
                fails++; $display("FAIL skip_launch_addr: got %0h,%0h expected 3000,3200", lq[bl].addr, lq[bl + 1].addr);
            end
            tests++;
            if (eq[be].id !== 4'd1 || eq[be].skip !== 1'b0) begin
                fails++; $display("FAIL skip_evt0: got id=%0d skip=%b expected 1/0", eq[be].id, eq[be].skip);
            end
            tests++;
            if (eq[be + 1].id !== 4'd7 || eq[be + 1].skip !== 1'b1) begin
                fails++; $display("FAIL skip_evt1: got id=%0d skip=%b expected 7/1", eq[be + 1].id, eq[be + 1].skip);
            end
            tests++;
            if (eq[be + 2].id !== 4'd2 || eq[be + 2].skip !== 1'b0) begin
                fails++; $display("FAIL skip_evt2: got id=%0d skip=%b expected 2/0", eq[be + 2].id, eq[be + 2].skip);
            end
            tests++;
            if (eq[be + 1].cyc != eq[be].cyc + 2 || lq[bl + 1].cyc != eq[be + 1].cyc + 2) begin
                fails++; $display("FAIL skip_timing: got evt1=%0d launch2=%0d expected %0d/%0d",
                    eq[be + 1].cyc, lq[bl + 1].cyc, eq[be].cyc + 2, eq[be].cyc + 4);
            end
        end
    endtask

    task automatic test_clear();
        int bl, be;
        bit ok;
        bl = lq.size(); be = eq.size();
        sk_lat = 40;
        push_job(32'h4000, 16'd4, 4'd1, ok);
        push_job(32'h4100, 16'd4, 4'd2, ok);
        push_job(32'h4200, 16'd4, 4'd3, ok);
        repeat (3) tick();
        @(negedge clk_i);
        tests++;
        if (lq.size() != bl + 1 || pending_o !== 2) begin
            fails++; $display("FAIL clear_pre: got launches=%0d pend=%0d expected 1/2", lq.size() - bl, pending_o);
        end
        tick();
        sk_clear = 1'b1;
        clear_i  = 1'b1;
        tick();
        clear_i  = 1'b0;
        sk_clear = 1'b0;
        @(negedge clk_i);
        tests++;
        if (pending_o !== '0 || busy_o !== 1'b0 || job_ready_o !== 1'b1) begin
            fails++; $display("FAIL clear_state: got pend=%0d busy=%b ready=%b expected 0/0/1", pending_o, busy_o, job_ready_o);
        end
        tests++;
        if (sink_req_start_o !== 1'b0 || evt_done_o !== 1'b0 || sink_addr_o !== '0 || sink_size_o !== '0) begin
            fails++; $display("FAIL clear_outputs: got req=%b done=%b addr=%0h size=%0h expected 0",
                sink_req_start_o, evt_done_o, sink_addr_o, sink_size_o);
        end
        repeat (60) tick();
        tests++;
        if (eq.size() != be || lq.size() != bl + 1) begin
            fails++; $display("FAIL clear_abandon: got events=%0d launches=%0d expected 0/1", eq.size() - be, lq.size() - bl);
        end
    endtask

    task automatic test_random();
        launch_t el[$];
        evt_t    ee[$];
        int bl, be, n, j;
        bit ok;
        logic [AW-1:0] a;
        logic [SW-1:0] s;
        logic [IW-1:0] id;
        bl = lq.size(); be = eq.size(); n = 24;
        sk_lat = int'($urandom_range(1, 6));
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            a  = $urandom;
            s  = ($urandom_range(0, 4) == 0) ? '0 : SW'($urandom_range(1, 255));
            id = IW'($urandom);
            push_job(a, s, id, ok);
            tests++;
            if (!ok) begin
                fails++; $display("FAIL rand_push_%0d: got no handshake expected accept", i);
            end
            if (s != '0) el.push_back('{a, s, 0});
            ee.push_back('{id, (s == '0), 0});
        end
        wait_events(be + n, ok);
        repeat (5) tick();
        tests++;
        if (!ok || eq.size() - be != ee.size() || lq.size() - bl != el.size()) begin
            fails++; $display("FAIL rand_counts: got events=%0d launches=%0d expected %0d/%0d",
                eq.size() - be, lq.size() - bl, ee.size(), el.size());
        end
        for (int i = 0; i < el.size() && bl + i < lq.size(); i++) begin
            tests++;
            if (lq[bl + i].addr !== el[i].addr || lq[bl + i].size !== el[i].size) begin
                fails++; $display("FAIL rand_launch_%0d: got %0h/%0d expected %0h/%0d",
                    i, lq[bl + i].addr, lq[bl + i].size, el[i].addr, el[i].size);
            end
        end
        j = 0;
        for (int i = 0; i < ee.size() && be + i < eq.size(); i++) begin
            tests++;
            if (eq[be + i].id !== ee[i].id || eq[be + i].skip !== ee[i].skip) begin
                fails++; $display("FAIL rand_evt_%0d: got id=%0d skip=%b expected %0d/%b",
                    i, eq[be + i].id, eq[be + i].skip, ee[i].id, ee[i].skip);
            end
            if (!ee[i].skip) begin
                if (bl + j < lq.size()) begin
                    tests++;
                    if (eq[be + i].cyc != lq[bl + j].cyc + sk_lat + 1) begin
                        fails++; $display("FAIL rand_evt_lat_%0d: got %0d expected %0d",
                            i, eq[be + i].cyc, lq[bl + j].cyc + sk_lat + 1);
                    end
                end
                j++;
            end
        end
        @(negedge clk_i);
        tests++;
        if (busy_o !== 1'b0 || pending_o !== '0) begin
            fails++; $display("FAIL rand_drained: got busy=%b pend=%0d expected 0/0", busy_o, pending_o);
        end
        tick();
    endtask

`ifdef SINK_JOB_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        int bl, be;
        bit ok;
        bl = lq.size(); be = eq.size();
        sk_never = 1'b1;
        push_job(32'h5000, 16'd4, 4'd5, ok);
        push_job(32'h5100, 16'd4, 4'd6, ok);
        wait_events(be + 1, ok);
        tests++;
        if (!ok || err_timeout_o !== 1'b1) begin
            fails++; $display("FAIL wd_err: got ok=%b err=%b expected 1/1", ok, err_timeout_o);
        end else begin
            tests++;
            if (eq[be].id !== 4'd5 || eq[be].skip !== 1'b1 || eq[be].cyc != lq[bl].cyc + 21) begin
                fails++; $display("FAIL wd_evt: got id=%0d skip=%b cyc=%0d expected 5/1/%0d",
                    eq[be].id, eq[be].skip, eq[be].cyc, lq[bl].cyc + 21);
            end
        end
        wait_events(be + 2, ok);
        tests++;
        if (!ok || lq.size() < bl + 2 || lq[bl + 1].cyc != lq[bl].cyc + 23 || lq[bl + 1].addr !== 32'h5100) begin
            fails++; $display("FAIL wd_next_launch: got launches=%0d expected 2 at +23", lq.size() - bl);
        end
        sk_never = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (err_timeout_o !== 1'b0) begin
            fails++; $display("FAIL wd_clear: got %b expected 0", err_timeout_o);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_skip();
        test_clear();
        test_random();
`ifdef SINK_JOB_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
        $fatal(1);
    end

endmodule
